// File: rtl/mesh_resp_writer_if.sv
// Bundles the mesh response stream, the write-request channel and the
// completion/overflow status of mesh_resp_writer into one interface.
// master: the environment (mesh + write sink). slave: the writer block.
interface mesh_resp_writer_if #(
    parameter int DIM    = 16,
    parameter int IN_W   = 20,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 14,
    parameter int ROB_W  = 6
);
    // Mesh response row and its tag
    logic                  in_resp_valid;
    logic [DIM*IN_W-1:0]   in_resp_data;
    logic                  in_resp_tag_rob_id_valid;
    logic [ROB_W-1:0]      in_resp_tag_rob_id;
    logic                  in_resp_tag_is_acc_addr;
    logic                  in_resp_tag_accumulate;
    logic                  in_resp_tag_is_garbage;
    logic [ADDR_W-1:0]     in_resp_tag_addr;
    logic [4:0]            in_resp_tag_rows;
    logic [4:0]            in_resp_tag_cols;
    logic                  in_resp_last;

    // Write request channel
    logic                  out_wr_valid;
    logic                  out_wr_ready;
    logic [ADDR_W-1:0]     out_wr_addr;
    logic                  out_wr_acc;
    logic                  out_wr_accumulate;
    logic [DIM*IN_W-1:0]   out_wr_data;
    logic [DIM*OUT_W-1:0]  out_wr_sp_data;
    logic [DIM-1:0]        out_wr_mask;

    // Completion and status
    logic                  out_done_valid;
    logic [ROB_W-1:0]      out_done_rob_id;
    logic                  out_overflow;

    modport master (
        output in_resp_valid, in_resp_data, in_resp_tag_rob_id_valid,
               in_resp_tag_rob_id, in_resp_tag_is_acc_addr,
               in_resp_tag_accumulate, in_resp_tag_is_garbage,
               in_resp_tag_addr, in_resp_tag_rows, in_resp_tag_cols,
               in_resp_last, out_wr_ready,
        input  out_wr_valid, out_wr_addr, out_wr_acc, out_wr_accumulate,
               out_wr_data, out_wr_sp_data, out_wr_mask,
               out_done_valid, out_done_rob_id, out_overflow
    );

    modport slave (
        input  in_resp_valid, in_resp_data, in_resp_tag_rob_id_valid,
               in_resp_tag_rob_id, in_resp_tag_is_acc_addr,
               in_resp_tag_accumulate, in_resp_tag_is_garbage,
               in_resp_tag_addr, in_resp_tag_rows, in_resp_tag_cols,
               in_resp_last, out_wr_ready,
        output out_wr_valid, out_wr_addr, out_wr_acc, out_wr_accumulate,
               out_wr_data, out_wr_sp_data, out_wr_mask,
               out_done_valid, out_done_rob_id, out_overflow
    );
endinterface

// File: rtl/mesh_resp_writer.sv
// Drains the systolic mesh response stream into scratchpad/accumulator
// write requests. Rows are buffered in a small FIFO (the mesh cannot be
// stalled), addressed from their tag, column-masked and saturated to
// OUT_W at the FIFO head. A done pulse follows the pop of a tile's last row.
module mesh_resp_writer #(
    parameter int DIM    = 16,
    parameter int IN_W   = 20,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 14,
    parameter int ROB_W  = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mesh_resp_writer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                wen;
        logic [DIM-1:0]      mask;
        logic [DIM*IN_W-1:0] data;
        logic                acc;
        logic                accumulate;
        logic                last;
        logic                rob_id_valid;
        logic [ROB_W-1:0]    rob_id;
    } entry_t;

    // Register-based storage: the head must be visible in the same cycle
    // it becomes valid, so the read port is combinational.
    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [4:0]         r_row_cnt;
    logic               r_done_valid;
    logic [ROB_W-1:0]   r_done_rob_id;
    logic               r_overflow;

    entry_t               w_head;
    entry_t               w_push_entry;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_done_fire;
    logic [DIM-1:0]       w_mask;
    logic [DIM*OUT_W-1:0] w_sp_data;

    // Column mask: element gi is writable when it lies inside the tile width
    for (genvar gi = 0; gi < DIM; gi++) begin : g_mask
        localparam logic [6:0] IDX = 7'(gi);
        assign w_mask[gi] = IDX < {2'b00, bus.in_resp_tag_cols};
    end

    // Saturate each head element to the signed OUT_W range. An element fits
    // when all bits from the OUT_W sign bit upward agree.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_sat
        logic [IN_W-1:0] w_elem;
        logic            w_fits;
        assign w_elem = w_head.data[gi*IN_W +: IN_W];
        assign w_fits = (&w_elem[IN_W-1:OUT_W-1]) | ~(|w_elem[IN_W-1:OUT_W-1]);
        assign w_sp_data[gi*OUT_W +: OUT_W] =
            w_fits          ? w_elem[OUT_W-1:0] :
            w_elem[IN_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                              {1'b0, {(OUT_W-1){1'b1}}};
    end

    assign w_head = r_mem[r_rd_ptr];

    // Entry built from the incoming row using the current row counter
    always_comb begin
        w_push_entry              = '0;
        w_push_entry.addr         = bus.in_resp_tag_addr + ADDR_W'(r_row_cnt);
        w_push_entry.wen          = !bus.in_resp_tag_is_garbage &&
                                    (r_row_cnt < bus.in_resp_tag_rows);
        w_push_entry.mask         = w_mask;
        w_push_entry.data         = bus.in_resp_data;
        w_push_entry.acc          = bus.in_resp_tag_is_acc_addr;
        w_push_entry.accumulate   = bus.in_resp_tag_accumulate;
        w_push_entry.last         = bus.in_resp_last;
        w_push_entry.rob_id_valid = bus.in_resp_tag_rob_id_valid;
        w_push_entry.rob_id       = bus.in_resp_tag_rob_id;
    end

    // FIFO control: non-writing heads retire on their own; a push into a
    // full FIFO survives only if the head leaves in the same cycle.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == (PTR_W+1)'(DEPTH));
        w_pop       = !w_empty && (!w_head.wen || bus.out_wr_ready);
        w_push      = bus.in_resp_valid && (!w_full || w_pop);
        w_drop      = bus.in_resp_valid && w_full && !w_pop;
        w_done_fire = w_pop && w_head.last && w_head.rob_id_valid;
    end

    // Entry storage; contents need no reset because occupancy gates use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Pointers, occupancy, row counter, done pulse and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_row_cnt     <= '0;
            r_done_valid  <= 1'b0;
            r_done_rob_id <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
            // Every valid row advances the counter, even a dropped one
            if (bus.in_resp_valid) begin
                r_row_cnt <= bus.in_resp_last ? 5'd0 : r_row_cnt + 5'd1;
            end
            r_done_valid <= w_done_fire;
            if (w_done_fire) begin
                r_done_rob_id <= w_head.rob_id;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_wr_valid      = !w_empty && w_head.wen;
    assign bus.out_wr_addr       = w_head.addr;
    assign bus.out_wr_acc        = w_head.acc;
    assign bus.out_wr_accumulate = w_head.accumulate;
    assign bus.out_wr_data       = w_head.data;
    assign bus.out_wr_sp_data    = w_sp_data;
    assign bus.out_wr_mask       = w_head.mask;
    assign bus.out_done_valid    = r_done_valid;
    assign bus.out_done_rob_id   = r_done_rob_id;
    assign bus.out_overflow      = r_overflow;

endmodule

// File: tb/tb_mesh_resp_writer.sv
// Directed and randomized bench for mesh_resp_writer. A queue-based model
// tracks buffered rows, expected writes, done pulses and overflow.
module tb_mesh_resp_writer;
    localparam int DIM    = 16;
    localparam int IN_W   = 20;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = 14;
    localparam int ROB_W  = 6;
    localparam int DEPTH  = 4;
    localparam int DW     = DIM*IN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mesh_resp_writer_if #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W),
                          .ADDR_W(ADDR_W), .ROB_W(ROB_W)) bus ();

    mesh_resp_writer #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
                       .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0]    addr;
        bit                   wen;
        logic [DIM-1:0]       mask;
        logic [DW-1:0]        data;
        logic [DIM*OUT_W-1:0] sp;
        bit                   acc;
        bit                   accum;
        bit                   last;
        bit                   robv;
        logic [ROB_W-1:0]     rob;
    } exp_t;

    exp_t             mq[$];
    int               m_row = 0;
    bit               m_done = 0;
    logic [ROB_W-1:0] m_done_id = '0;
    bit               m_ovf = 0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        int v;
        d = '0;
        for (int i = 0; i < DIM; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 255)) - 128;
                1: v = int'($urandom_range(0, 524287));
                2: v = -int'($urandom_range(1, 524288));
                default: case ($urandom_range(0, 3))
                    0: v = 127;
                    1: v = 128;
                    2: v = -128;
                    default: v = -129;
                endcase
            endcase
            d[i*IN_W +: IN_W] = v[IN_W-1:0];
        end
        return d;
    endfunction

    task automatic compare_outputs();
        bit ev;
        ev = (mq.size() > 0) && mq[0].wen;
        check("wr_valid", DW'(bus.out_wr_valid), DW'(ev));
        if (ev) begin
            check("wr_addr", DW'(bus.out_wr_addr), DW'(mq[0].addr));
            check("wr_acc", DW'(bus.out_wr_acc), DW'(mq[0].acc));
            check("wr_accumulate", DW'(bus.out_wr_accumulate), DW'(mq[0].accum));
            check("wr_mask", DW'(bus.out_wr_mask), DW'(mq[0].mask));
            check("wr_data", bus.out_wr_data, mq[0].data);
            check("wr_sp_data", DW'(bus.out_wr_sp_data), DW'(mq[0].sp));
        end
        check("done_valid", DW'(bus.out_done_valid), DW'(m_done));
        if (m_done) begin
            check("done_rob_id", DW'(bus.out_done_rob_id), DW'(m_done_id));
        end
        check("overflow", DW'(bus.out_overflow), DW'(m_ovf));
    endtask

    // One clock: check current outputs, advance the model, cross the edge
    task automatic cycle();
        exp_t e;
        bit pop, full, keep;
        logic signed [IN_W-1:0] el;
        int v;
        compare_outputs();
        $display("t=%0t valid=%0b addr=%0h ready=%0b wr_valid=%0b wr_addr=%0h done=%0b ovf=%0b",
                 $time, bus.in_resp_valid, bus.in_resp_tag_addr, bus.out_wr_ready,
                 bus.out_wr_valid, bus.out_wr_addr, bus.out_done_valid, bus.out_overflow);
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && (!mq[0].wen || bus.out_wr_ready);
        m_done = pop && mq[0].last && mq[0].robv;
        if (m_done) m_done_id = mq[0].rob;
        keep = 0;
        if (bus.in_resp_valid) begin
            e.addr  = bus.in_resp_tag_addr + ADDR_W'(m_row);
            e.wen   = !bus.in_resp_tag_is_garbage && (m_row < int'(bus.in_resp_tag_rows));
            for (int i = 0; i < DIM; i++) e.mask[i] = (i < int'(bus.in_resp_tag_cols));
            e.data  = bus.in_resp_data;
            for (int i = 0; i < DIM; i++) begin
                el = e.data[i*IN_W +: IN_W];
                v = el;
                if (v > 127) v = 127;
                else if (v < -128) v = -128;
                e.sp[i*OUT_W +: OUT_W] = v[7:0];
            end
            e.acc   = bus.in_resp_tag_is_acc_addr;
            e.accum = bus.in_resp_tag_accumulate;
            e.last  = bus.in_resp_last;
            e.robv  = bus.in_resp_tag_rob_id_valid;
            e.rob   = bus.in_resp_tag_rob_id;
            if (full && !pop) m_ovf = 1;
            else keep = 1;
            m_row = bus.in_resp_last ? 0 : (m_row + 1) % 32;
        end
        if (pop) void'(mq.pop_front());
        if (keep) mq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic [ADDR_W-1:0] addr, input int rows, input int cols,
                       input bit acc, input bit accum, input bit garbage, input bit last,
                       input bit robv, input logic [ROB_W-1:0] rob,
                       input logic [DW-1:0] data, input bit ready);
        bus.in_resp_valid            = 1'b1;
        bus.in_resp_tag_addr         = addr;
        bus.in_resp_tag_rows         = 5'(rows);
        bus.in_resp_tag_cols         = 5'(cols);
        bus.in_resp_tag_is_acc_addr  = acc;
        bus.in_resp_tag_accumulate   = accum;
        bus.in_resp_tag_is_garbage   = garbage;
        bus.in_resp_last             = last;
        bus.in_resp_tag_rob_id_valid = robv;
        bus.in_resp_tag_rob_id       = rob;
        bus.in_resp_data             = data;
        bus.out_wr_ready             = ready;
        cycle();
        bus.in_resp_valid            = 1'b0;
    endtask

    task automatic idle(input int n, input bit ready);
        for (int k = 0; k < n; k++) begin
            bus.in_resp_valid = 1'b0;
            bus.out_wr_ready  = ready;
            cycle();
        end
    endtask

    task automatic reset_check();
        check("rst_wr_valid", DW'(bus.out_wr_valid), DW'(1'b0));
        check("rst_done_valid", DW'(bus.out_done_valid), DW'(1'b0));
        check("rst_done_rob_id", DW'(bus.out_done_rob_id), DW'(0));
        check("rst_overflow", DW'(bus.out_overflow), DW'(1'b0));
    endtask

    task automatic model_reset();
        mq.delete();
        m_row = 0;
        m_done = 0;
        m_done_id = '0;
        m_ovf = 0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int v;
        logic [ADDR_W-1:0] base;
        int rows, cols, n;
        bit acc, accum, robv;
        logic [ROB_W-1:0] rob;

        bus.in_resp_valid = 0; bus.in_resp_data = '0; bus.in_resp_tag_rob_id_valid = 0;
        bus.in_resp_tag_rob_id = '0; bus.in_resp_tag_is_acc_addr = 0;
        bus.in_resp_tag_accumulate = 0; bus.in_resp_tag_is_garbage = 0;
        bus.in_resp_tag_addr = '0; bus.in_resp_tag_rows = '0; bus.in_resp_tag_cols = '0;
        bus.in_resp_last = 0; bus.out_wr_ready = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_check();
        rst = 1'b0;

        // Basic tile: 4 rows at 0x100, all columns, accumulator target
        for (int r = 0; r < 4; r++)
            row(14'h100, 4, 16, 1, 0, 0, r == 3, 1, 6'd5, rand_data(), 1);
        idle(3, 1);

        // Saturation and masking, scratchpad target, 3 columns
        d = rand_data();
        v = 300;  d[0*IN_W +: IN_W] = v[IN_W-1:0];
        v = -300; d[1*IN_W +: IN_W] = v[IN_W-1:0];
        v = 127;  d[2*IN_W +: IN_W] = v[IN_W-1:0];
        v = -128; d[3*IN_W +: IN_W] = v[IN_W-1:0];
        row(14'h200, 1, 3, 0, 0, 0, 1, 1, 6'd6, d, 1);
        check("sat_sp_low4", DW'(bus.out_wr_sp_data[31:0]), DW'(32'h80_7F_80_7F));
        check("sat_mask", DW'(bus.out_wr_mask), DW'(16'h0007));
        idle(1, 1);
        idle(1, 1);

        // Dropped rows: rows=2 with row 1 garbage, 4 response rows
        for (int r = 0; r < 4; r++)
            row(14'h100, 2, 16, 1, 1, r == 1, r == 3, 1, 6'd7, rand_data(), 1);
        idle(3, 1);

        // Full FIFO with simultaneous push and pop: no loss
        for (int r = 0; r < 4; r++)
            row(14'h280, 8, 16, 1, 0, 0, 0, 1, 6'd8, rand_data(), 0);
        row(14'h280, 8, 16, 1, 0, 0, 1, 1, 6'd8, rand_data(), 1);
        idle(6, 1);

        // Backpressure then overflow: 5 rows into a 4-deep FIFO
        for (int r = 0; r < 5; r++)
            row(14'h300, 5, 16, 0, 0, 0, r == 4, 1, 6'd10, rand_data(), 0);
        idle(2, 0);
        check("overflow_sticky", DW'(bus.out_overflow), DW'(1'b1));
        idle(6, 1);

        // Reset in the middle of a tile
        for (int r = 0; r < 2; r++)
            row(14'h400, 4, 16, 1, 0, 0, 0, 1, 6'd11, rand_data(), 0);
        rst = 1'b1;
        #2;
        model_reset();
        reset_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 4; r++)
            row(14'h500, 4, 16, 1, 0, 0, r == 3, 1, 6'd12, rand_data(), 1);
        idle(3, 1);

        // Randomized tiles with random gaps and backpressure
        for (int t = 0; t < 40; t++) begin
            base  = ADDR_W'($urandom);
            rows  = $urandom_range(1, 16);
            cols  = $urandom_range(1, 16);
            n     = $urandom_range(1, 6);
            acc   = 1'($urandom_range(0, 1));
            accum = 1'($urandom_range(0, 1));
            robv  = ($urandom_range(0, 3) != 0);
            rob   = ROB_W'($urandom);
            for (int r = 0; r < n; r++) begin
                if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
                row(base, rows, cols, acc, accum, $urandom_range(0, 7) == 0, r == n - 1,
                    robv, rob, rand_data(), $urandom_range(0, 2) != 0);
            end
        end
        idle(10, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
